// File: rtl/dma_pkg.sv
// Shared DMA definitions: default widths and FIFO read-mode encodings.
package dma_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 4;

  // Read-side presentation mode of the FIFO
  typedef enum logic {
    FWFT_OFF = 1'b0,
    FWFT_ON  = 1'b1
  } fwft_mode_e;

  // True when an integer mode parameter selects first-word-fall-through
  function automatic bit is_fwft(input int mode);
    return mode == int'(FWFT_ON);
  endfunction

endpackage

// File: rtl/dma_fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset; stale words are never observable because
// the pointer logic in dma_fifo decides what is valid.
module dma_fifo_mem
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the incoming word when the controller accepts a write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dma_fifo.sv
// DMA FIFO controller: wrap-bit pointers, registered status flags, sticky
// error flags and the read-data output stage (registered-read or FWFT).
module dma_fifo
  import dma_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int FWFT       = int'(FWFT_OFF),
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  ren,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam bit FWFT_MODE = is_fwft(FWFT);
  localparam logic [PW-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         wr_next, rd_next;
  logic [PW-1:0]         level_next;
  logic                  rd_acc, wr_acc;
  logic                  mem_we;
  logic                  ovf_set, unf_set;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] head_next;

  // Registered empty/full flags equal the pointer comparisons, so they can
  // gate acceptance without any combinational path from wen/ren to outputs.
  assign rd_acc = ren && !fifo_empty;
  assign wr_acc = wen && (!fifo_full || rd_acc);
  assign mem_we = rst_n && !flush && wr_acc;

  assign ovf_set = !flush && wen && fifo_full && !rd_acc;
  assign unf_set = !flush && ren && fifo_empty;

  // Next pointer values; reset and flush both collapse the FIFO to empty
  always_comb begin
    wr_next = wr_ptr;
    rd_next = rd_ptr;
    if (!rst_n || flush) begin
      wr_next = '0;
      rd_next = '0;
    end else begin
      if (rd_acc) rd_next = rd_ptr + PTR_ONE;
      if (wr_acc) wr_next = wr_ptr + PTR_ONE;
    end
  end

  assign level_next = wr_next - rd_next;

  // FWFT needs the word that will be at the head after this edge; the
  // registered-read mode needs the word at the current head.
  assign rd_addr = FWFT_MODE ? rd_next[ADDR_WIDTH-1:0] : rd_ptr[ADDR_WIDTH-1:0];

  // A write into an empty-after-read FIFO lands on the head slot this very
  // edge, so the incoming word must bypass the array.
  assign head_next = (wr_acc && (wr_ptr == rd_next)) ? data_in : rd_data;

  dma_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // Pointers and all status flags, registered from next-state values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      fifo_empty   <= 1'b1;
      fifo_full    <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_next;
      rd_ptr       <= rd_next;
      level        <= level_next;
      fifo_empty   <= (wr_next == rd_next);
      fifo_full    <= (wr_next[ADDR_WIDTH] != rd_next[ADDR_WIDTH]) &&
                      (wr_next[ADDR_WIDTH-1:0] == rd_next[ADDR_WIDTH-1:0]);
      almost_empty <= 32'(level_next) <= AE_THRESH;
      almost_full  <= 32'(level_next) >= AF_THRESH;
      overflow     <= (overflow  && !err_clr) || ovf_set;
      underflow    <= (underflow && !err_clr) || unf_set;
    end
  end

  // Read-data output stage: head tracking in FWFT, one-cycle pulse otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (flush) begin
      data_valid <= 1'b0;
    end else if (FWFT_MODE) begin
      data_out   <= head_next;
      data_valid <= (wr_next != rd_next);
    end else begin
      data_valid <= rd_acc;
      if (rd_acc) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_dma_fifo.sv
// Testbench for dma_fifo: one registered-read and one FWFT instance share the
// same stimulus and are compared against a queue-based reference model.
module tb_dma_fifo;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 14;
  localparam int AET   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wen = 1'b0;
  logic          ren = 1'b0;
  logic          err_clr = 1'b0;

  logic [DW-1:0] d0_data_out, d1_data_out;
  logic          d0_valid, d1_valid;
  logic          d0_full, d1_full, d0_empty, d1_empty;
  logic          d0_af, d1_af, d0_ae, d1_ae;
  logic [AW:0]   d0_level, d1_level;
  logic          d0_ovf, d1_ovf, d0_unf, d1_unf;

  int checkCount = 0;
  int passCount  = 0;

  logic [DW-1:0] modelQ[$];
  logic          expOvf = 1'b0;
  logic          expUnf = 1'b0;
  logic [DW-1:0] expDout0 = '0;
  logic          expValid0 = 1'b0;

  always #5 clk = ~clk;

  dma_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
             .AF_THRESH(AFT), .AE_THRESH(AET)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
    .wen(wen), .ren(ren), .err_clr(err_clr),
    .data_out(d0_data_out), .data_valid(d0_valid),
    .fifo_full(d0_full), .fifo_empty(d0_empty),
    .almost_full(d0_af), .almost_empty(d0_ae),
    .level(d0_level), .overflow(d0_ovf), .underflow(d0_unf)
  );

  dma_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
             .AF_THRESH(AFT), .AE_THRESH(AET)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .data_in(data_in),
    .wen(wen), .ren(ren), .err_clr(err_clr),
    .data_out(d1_data_out), .data_valid(d1_valid),
    .fifo_full(d1_full), .fifo_empty(d1_empty),
    .almost_full(d1_af), .almost_empty(d1_ae),
    .level(d1_level), .overflow(d1_ovf), .underflow(d1_unf)
  );

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference behaviour for one clock edge, from the FIFO's rules
  task automatic modelEdge(input logic w, input logic r, input logic [DW-1:0] d,
                           input logic f, input logic ec, input logic rs);
    int  sz;
    bit  racc, wacc, newOvf, newUnf;
    sz = modelQ.size();
    if (!rs) begin
      modelQ.delete();
      expOvf = 1'b0;
      expUnf = 1'b0;
      expDout0 = '0;
      expValid0 = 1'b0;
    end else if (f) begin
      modelQ.delete();
      expValid0 = 1'b0;
      if (ec) begin
        expOvf = 1'b0;
        expUnf = 1'b0;
      end
    end else begin
      racc   = r && (sz > 0);
      wacc   = w && ((sz < DEPTH) || racc);
      newOvf = w && (sz == DEPTH) && !racc;
      newUnf = r && (sz == 0);
      expValid0 = racc;
      if (racc) expDout0 = modelQ.pop_front();
      if (wacc) modelQ.push_back(d);
      expOvf = (expOvf && !ec) || newOvf;
      expUnf = (expUnf && !ec) || newUnf;
    end
  endtask

  // Compare every observable output of both instances with the model
  task automatic checkAll();
    int sz;
    sz = modelQ.size();
    checkOutput("level0", 32'(d0_level), sz);
    checkOutput("level1", 32'(d1_level), sz);
    checkOutput("empty0", 32'(d0_empty), 32'(sz == 0));
    checkOutput("empty1", 32'(d1_empty), 32'(sz == 0));
    checkOutput("full0", 32'(d0_full), 32'(sz == DEPTH));
    checkOutput("full1", 32'(d1_full), 32'(sz == DEPTH));
    checkOutput("afull0", 32'(d0_af), 32'(sz >= AFT));
    checkOutput("afull1", 32'(d1_af), 32'(sz >= AFT));
    checkOutput("aempty0", 32'(d0_ae), 32'(sz <= AET));
    checkOutput("aempty1", 32'(d1_ae), 32'(sz <= AET));
    checkOutput("ovf0", 32'(d0_ovf), 32'(expOvf));
    checkOutput("ovf1", 32'(d1_ovf), 32'(expOvf));
    checkOutput("unf0", 32'(d0_unf), 32'(expUnf));
    checkOutput("unf1", 32'(d1_unf), 32'(expUnf));
    checkOutput("valid0", 32'(d0_valid), 32'(expValid0));
    checkOutput("dout0", d0_data_out, expDout0);
    checkOutput("valid1", 32'(d1_valid), 32'(sz > 0));
    if (sz > 0) checkOutput("dout1", d1_data_out, modelQ[0]);
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check
  task automatic applyStimulus(input logic w, input logic r, input logic [DW-1:0] d,
                               input logic f, input logic ec, input logic rs);
    wen = w; ren = r; data_in = d; flush = f; err_clr = ec; rst_n = rs;
    @(posedge clk);
    modelEdge(w, r, d, f, ec, rs);
    #1;
    checkAll();
  endtask

  task automatic doWrite(input logic [DW-1:0] d);
    applyStimulus(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic doRead();
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    doReset();
    doReset();
    checkOutput("rst_empty", 32'(d0_empty), 32'd1);

    // Fill to full, one extra write overflows, then drain in order
    for (int i = 0; i < DEPTH; i++) doWrite(32'(i));
    doWrite(32'hDEAD);
    checkOutput("fill_full", 32'(d0_full), 32'd1);
    checkOutput("fill_level", 32'(d0_level), 32'd16);
    checkOutput("fill_ovf", 32'(d0_ovf), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      doRead();
      checkOutput("drain_order", d0_data_out, 32'(i));
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Registered-read latency
    doWrite(32'hA5);
    doRead();
    checkOutput("a5_dout", d0_data_out, 32'hA5);
    checkOutput("a5_valid", 32'(d0_valid), 32'd1);
    doIdle();
    checkOutput("a5_pulse", 32'(d0_valid), 32'd0);

    // FWFT head presentation
    doWrite(32'h11);
    doWrite(32'h22);
    checkOutput("fwft_head", d1_data_out, 32'h11);
    doRead();
    checkOutput("fwft_next", d1_data_out, 32'h22);
    doRead();

    // Write at full with concurrent read
    for (int i = 0; i < DEPTH; i++) doWrite(32'h100 + 32'(i));
    applyStimulus(1'b1, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    checkOutput("wr_at_full_level", 32'(d0_level), 32'd16);
    checkOutput("wr_at_full_ovf", 32'(d0_ovf), 32'd0);
    for (int i = 0; i < DEPTH; i++) doRead();
    checkOutput("wr_at_full_last", d0_data_out, 32'h99);

    // Simultaneous write and read at empty, then flush keeps sticky underflow
    applyStimulus(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, 1'b1);
    checkOutput("wr_rd_empty_unf", 32'(d0_unf), 32'd1);
    for (int i = 0; i < 4; i++) doWrite(32'h200 + 32'(i));
    applyStimulus(1'b1, 1'b0, 32'hBAD, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_level", 32'(d0_level), 32'd0);
    checkOutput("flush_unf", 32'(d0_unf), 32'd1);
    doIdle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("errclr_unf", 32'(d0_unf), 32'd0);

    // Error set together with err_clr keeps the flag
    applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1);
    checkOutput("err_wins", 32'(d0_unf), 32'd1);

    // Thresholds and reset mid-operation
    for (int i = 0; i < 14; i++) doWrite(32'h300 + 32'(i));
    checkOutput("af_14", 32'(d0_af), 32'd1);
    for (int i = 0; i < 12; i++) doRead();
    checkOutput("ae_2", 32'(d0_ae), 32'd1);
    for (int i = 0; i < 5; i++) doWrite(32'h400 + 32'(i));
    applyStimulus(1'b1, 1'b1, 32'h5, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_level", 32'(d0_level), 32'd0);
    checkOutput("rst_dout", d0_data_out, 32'd0);

    // Randomized traffic with drifting write/read bias
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = ((i / 60) % 2 == 0) ? 75 : 25;
      applyStimulus(logic'($urandom_range(0, 99) < bias),
                    logic'($urandom_range(0, 99) >= bias),
                    $urandom(),
                    logic'($urandom_range(0, 99) < 2),
                    logic'($urandom_range(0, 99) < 5),
                    logic'($urandom_range(0, 199) != 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
